// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

endpackage : tdm_pkg

// File: rtl/tdm_slot_steer.sv
// 1-to-4 registered demux that holds slots 0..2 of the frame under assembly.
// Slot 3 is never stored here; the top takes it straight from din.
module tdm_slot_steer
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic [SLOT_W-1:0] slot,
  input  logic              we,
  input  logic              clr,
  output logic [WIDTH-1:0]  shadow0,
  output logic [WIDTH-1:0]  shadow1,
  output logic [WIDTH-1:0]  shadow2
);

  logic [WIDTH-1:0] shadow0_r;
  logic [WIDTH-1:0] shadow1_r;
  logic [WIDTH-1:0] shadow2_r;

  // Shadow storage: clear first, then a same-cycle write overrides its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0_r <= {WIDTH{1'b0}};
      shadow1_r <= {WIDTH{1'b0}};
      shadow2_r <= {WIDTH{1'b0}};
    end else begin
      if (clr) begin
        shadow0_r <= {WIDTH{1'b0}};
        shadow1_r <= {WIDTH{1'b0}};
        shadow2_r <= {WIDTH{1'b0}};
      end
      if (we) begin
        case (slot)
          2'd0:    shadow0_r <= din;
          2'd1:    shadow1_r <= din;
          2'd2:    shadow2_r <= din;
          default: begin end
        endcase
      end
    end
  end

  assign shadow0 = shadow0_r;
  assign shadow1 = shadow1_r;
  assign shadow2 = shadow2_r;

endmodule : tdm_slot_steer

// File: rtl/tdm_demux_4ch.sv
// Receive side of the 4-channel TDM link: frame alignment, slot steering and
// publication of complete frames on ch0..ch3.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

  tdm_state_t        state_r, state_s;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [SLOT_W-1:0] wslot_s;
  logic              we_s, clr_s, complete_s, err_s;

  logic [WIDTH-1:0]  shadow0_s, shadow1_s, shadow2_s;
  logic [WIDTH-1:0]  ch0_r, ch1_r, ch2_r, ch3_r;
  logic              frame_valid_r, sync_err_r, locked_r;
  logic [CNT_W-1:0]  frame_cnt_r;

  tdm_slot_steer #(.WIDTH(WIDTH)) u_steer (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .slot    (wslot_s),
    .we      (we_s),
    .clr     (clr_s),
    .shadow0 (shadow0_s),
    .shadow1 (shadow1_s),
    .shadow2 (shadow2_s)
  );

  // Alignment FSM: next state, slot index and steering controls per beat.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    wslot_s    = slot_r;
    we_s       = 1'b0;
    clr_s      = 1'b0;
    complete_s = 1'b0;
    err_s      = 1'b0;
    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (frame_sync) begin
            clr_s   = 1'b1;
            we_s    = 1'b1;
            wslot_s = 2'd0;
            slot_s  = 2'd1;
            state_s = LOCKED;
          end else begin
            slot_s  = 2'd0;
          end
        end
        LOCKED: begin
          if (slot_r == 2'd0) begin
            if (frame_sync) begin
              we_s    = 1'b1;
              wslot_s = 2'd0;
              slot_s  = 2'd1;
            end else begin
              err_s   = 1'b1;
              clr_s   = 1'b1;
              slot_s  = 2'd0;
              state_s = HUNT;
            end
          end else if (frame_sync) begin
            // Early sync restarts the frame on this beat.
            err_s   = 1'b1;
            clr_s   = 1'b1;
            we_s    = 1'b1;
            wslot_s = 2'd0;
            slot_s  = 2'd1;
          end else if (slot_r == SLOT_LAST) begin
            complete_s = 1'b1;
            slot_s     = 2'd0;
          end else begin
            we_s   = 1'b1;
            slot_s = slot_r + 2'd1;
          end
        end
        default: begin
          state_s = HUNT;
          slot_s  = 2'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, slot counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= HUNT;
      slot_r        <= 2'd0;
      ch0_r         <= {WIDTH{1'b0}};
      ch1_r         <= {WIDTH{1'b0}};
      ch2_r         <= {WIDTH{1'b0}};
      ch3_r         <= {WIDTH{1'b0}};
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      locked_r      <= 1'b0;
      frame_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      slot_r        <= slot_s;
      frame_valid_r <= complete_s;
      sync_err_r    <= err_s;
      locked_r      <= (state_s == LOCKED);
      if (complete_s) begin
        ch0_r       <= shadow0_s;
        ch1_r       <= shadow1_s;
        ch2_r       <= shadow2_s;
        ch3_r       <= din;
        frame_cnt_r <= frame_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign ch0         = ch0_r;
  assign ch1         = ch1_r;
  assign ch2         = ch2_r;
  assign ch3         = ch3_r;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign locked      = locked_r;
  assign frame_cnt   = frame_cnt_r;

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
// Directed self-checking bench for tdm_demux_4ch with WIDTH=4, CNT_W=8.
module tb_tdm_demux_4ch;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [CNT_W-1:0] frame_cnt;

  int tests_run;
  int tests_failed;

  tdm_demux_4ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic fs, input logic [WIDTH-1:0] d);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    chk({tag, ".ch0"}, 32'(ch0), 32'(a));
    chk({tag, ".ch1"}, 32'(ch1), 32'(b));
    chk({tag, ".ch2"}, 32'(ch2), 32'(c));
    chk({tag, ".ch3"}, 32'(ch3), 32'(d));
  endtask

  task automatic do_reset();
    din        = 4'h0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    do_reset();

    // Reset state after idle cycles
    repeat (6) step(1'b0, 1'b0, 4'h0);
    chk_frame("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rst.fv", 32'(frame_valid), 32'd0);
    chk("rst.err", 32'(sync_err), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.cnt", 32'(frame_cnt), 32'd0);

    // First frame A,B,C,D from HUNT
    step(1'b1, 1'b1, 4'hA);
    chk("f1.locked", 32'(locked), 32'd1);
    chk("f1.fv0", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'hC);
    chk("f1.fv2", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'hD);
    chk_frame("f1", 4'hA, 4'hB, 4'hC, 4'hD);
    chk("f1.fv", 32'(frame_valid), 32'd1);
    chk("f1.cnt", 32'(frame_cnt), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    chk("f1.fv_drop", 32'(frame_valid), 32'd0);

    // Back-to-back frames, then a frame with an idle gap
    do_reset();
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    chk("b2b1.fv", 32'(frame_valid), 32'd1);
    chk_frame("b2b1", 4'h1, 4'h2, 4'h3, 4'h4);
    step(1'b1, 1'b1, 4'h5);
    chk("b2b2.fv_low", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h8);
    chk("b2b2.fv", 32'(frame_valid), 32'd1);
    chk_frame("b2b2", 4'h5, 4'h6, 4'h7, 4'h8);
    step(1'b1, 1'b1, 4'h9);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h4);
    step(1'b0, 1'b1, 4'h5);
    chk("gap.fv", 32'(frame_valid), 32'd0);
    chk("gap.err", 32'(sync_err), 32'd0);
    chk_frame("gap_hold", 4'h5, 4'h6, 4'h7, 4'h8);
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'hC);
    chk_frame("gap", 4'h9, 4'hA, 4'hB, 4'hC);
    chk("gap.fv_hi", 32'(frame_valid), 32'd1);
    chk("gap.cnt", 32'(frame_cnt), 32'd3);

    // Early sync on slot 2 restarts the frame
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b1, 4'h3);
    chk("early.err", 32'(sync_err), 32'd1);
    chk("early.locked", 32'(locked), 32'd1);
    chk("early.fv", 32'(frame_valid), 32'd0);
    chk_frame("early_hold", 4'h9, 4'hA, 4'hB, 4'hC);
    step(1'b1, 1'b0, 4'h4);
    chk("early.err_drop", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h6);
    chk_frame("early", 4'h3, 4'h4, 4'h5, 4'h6);
    chk("early.fv_hi", 32'(frame_valid), 32'd1);
    chk("early.cnt", 32'(frame_cnt), 32'd4);

    // Missing sync at slot 0 drops lock; next sync re-locks
    step(1'b1, 1'b0, 4'hF);
    chk("miss.err", 32'(sync_err), 32'd1);
    chk("miss.locked", 32'(locked), 32'd0);
    chk("miss.fv", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b1, 4'hE);
    chk("miss.relock", 32'(locked), 32'd1);
    chk("miss.err_drop", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    chk_frame("miss", 4'hE, 4'h1, 4'h2, 4'h3);
    chk("miss.cnt", 32'(frame_cnt), 32'd5);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b1, 4'h7);
    step(1'b1, 1'b0, 4'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_frame("arst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("arst.locked", 32'(locked), 32'd0);
    chk("arst.cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hB);
    chk("arst.hunt_fv", 32'(frame_valid), 32'd0);
    chk("arst.hunt_locked", 32'(locked), 32'd0);
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    chk("arst.fv_early", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'h4);
    chk("arst.fv", 32'(frame_valid), 32'd1);
    chk_frame("arst_frame", 4'h1, 4'h2, 4'h3, 4'h4);
    chk("arst.cnt1", 32'(frame_cnt), 32'd1);

    // Frame counter wrap after 256 frames
    do_reset();
    for (int f = 0; f < 256; f++) begin
      step(1'b1, 1'b1, 4'(f));
      step(1'b1, 1'b0, 4'(f + 1));
      step(1'b1, 1'b0, 4'(f + 2));
      step(1'b1, 1'b0, 4'(f + 3));
      if (f == 254) chk("wrap.cnt255", 32'(frame_cnt), 32'd255);
    end
    chk("wrap.cnt0", 32'(frame_cnt), 32'd0);
    chk("wrap.fv", 32'(frame_valid), 32'd1);
    chk("wrap.err", 32'(sync_err), 32'd0);
    chk_frame("wrap", 4'hF, 4'h0, 4'h1, 4'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_tdm_demux_4ch

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive end of the 4-channel time-division link driven by the team's 4:1 mux path.
- Accepts one serial word stream with a frame marker and steers consecutive slots into four channel outputs: slot 0 → ch0 through slot 3 → ch3.
- Buffers a partial frame internally; the channel outputs update only on complete frames.
- Detects loss of frame alignment and resynchronises.

Parameters:
- WIDTH, 1, bits per slot word (legal range 1..32).
- CNT_W, 8, width of the good-frame counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset.
- din  in  WIDTH  slot data word.
- din_valid  in  1  din carries a slot word this cycle.
- frame_sync  in  1  marks the current beat as slot 0; qualified by din_valid.
- ch0, ch1, ch2, ch3  out  WIDTH each  last complete frame, slots 0..3.
- frame_valid  out  1  one-cycle pulse when ch0..ch3 were just updated.
- sync_err  out  1  one-cycle pulse on an alignment error.
- locked  out  1  high while in LOCKED.
- frame_cnt  out  CNT_W  count of complete frames, wraps.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: ch0..ch3, frame_valid, sync_err, locked, frame_cnt, slot counter and shadow registers all 0; state is HUNT.
- Reset mid-frame discards any partial frame.
- All outputs are registered.
- Beats: only cycles with din_valid=1 are beats. frame_sync with din_valid=0 is ignored. Idle cycles between beats are legal and change nothing.
- State HUNT:
  - A beat with frame_sync=0 is discarded.
  - A beat with frame_sync=1 stores din in shadow0, sets slot=1 and moves to LOCKED.
- State LOCKED, on a beat with slot=0:
  - frame_sync=1 → normal: store shadow0, slot=1.
  - frame_sync=0 → missing sync: sync_err pulse, beat discarded, go to HUNT, slot=0.
- State LOCKED, on a beat with slot=1..2:
  - frame_sync=0 → store shadow[slot], slot increments.
  - frame_sync=1 → early sync: sync_err pulse, partial frame discarded, din stored as shadow0, slot=1, stay LOCKED.
- State LOCKED, on a beat with slot=3:
  - frame_sync=0 → frame completes. On the same edge: ch0..ch2 ← shadow0..2, ch3 ← din, frame_valid=1 for exactly one cycle, frame_cnt increments (wraps to 0 from all-ones), slot=0.
  - frame_sync=1 → early sync: handled as for slot 1..2, with no frame output.
- Latency: outputs and frame_valid are visible in the cycle after the edge that samples the slot-3 beat.
- Outputs hold their values until the next complete frame.
- locked = (state == LOCKED), registered with the state.
- Back-to-back frames with no idle cycles are supported: frame_valid may pulse every 4 cycles.
- sync_err and frame_valid are never high in the same cycle.

Decomposition:
- Package tdm_pkg holds:
  - state typedef {HUNT, LOCKED};
  - NUM_SLOTS = 4;
  - SLOT_W = 2.
- One sub-module, tdm_slot_steer: a 1-to-4 registered demux. Inputs are din, slot index, write-enable and clear. Outputs are shadow0..2. It is instantiated once.
- The state machine, output registers and frame counter remain in tdm_demux_4ch.

Test Plan (WIDTH=4):
- Reset released, then 6 idle cycles → all outputs 0, locked=0.
- HUNT, then beats 0xA(sync), 0xB, 0xC, 0xD → locked=1 after the first beat. One cycle after the 0xD edge: ch0..ch3=A,B,C,D, frame_valid=1 for one cycle, frame_cnt=1.
- Two back-to-back frames 1,2,3,4 then 5,6,7,8, then din_valid dropped for 3 cycles mid-frame inside a third frame 9,_,_,A,B,C → frame_valid pulses at beats 4 and 8. The third frame completes as 9,A,B,C (idle cycles ignored). frame_cnt=3.
- LOCKED, beats 1(sync), 2, 3(sync), 4, 5, 6 → sync_err pulse on the third beat. Output frame = 3,4,5,6; ch never shows 1 or 2.
- LOCKED at slot 0, beat 0xF with frame_sync=0 → sync_err pulse, locked=0, 0xF not captured. A following 0xE(sync) re-locks.
- rst_n asserted asynchronously after two beats of a frame → all outputs 0 immediately. After release, a full frame is required before frame_valid.
- Frame counter: force 256 good frames → frame_cnt wraps to 0 (CNT_W=8).
